// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 keystream sequencing path.
// Block geometry and the controller state encoding live here.
package chacha_pkg;

    localparam int unsigned CTR_W       = 32;
    localparam int unsigned BLOCK_BYTES = 64;

    typedef logic [CTR_W-1:0] word_t;

    typedef enum logic [2:0] {
        StIdle,
        StGen,
        StWait,
        StLoad,
        StStream,
        StFin
    } ctrl_state_t;

endpackage

// File: rtl/chacha_keystream_ctrl.sv
// Keystream sequencer: runs the ChaCha20 block core one block at a time and
// meters serialiser bytes downstream until the requested length is consumed.
module chacha_keystream_ctrl
    import chacha_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      init_ctr,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             abort,
    output logic             core_start,
    output logic [31:0]      core_ctr,
    input  logic             core_done,
    output logic             ser_load,
    output logic             ser_step,
    input  logic [7:0]       ser_byte,
    output logic [7:0]       ks_byte,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic             ks_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned BLK_W = $clog2(BLOCK_BYTES);

    ctrl_state_t      state_q, state_d;
    word_t            ctr_q, ctr_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             err_q, err_d;
    logic             beat;

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        remaining_d = remaining_q;
        blk_cnt_d   = blk_cnt_q;
        err_d       = err_q;
        core_start  = 1'b0;
        ser_load    = 1'b0;
        ks_valid    = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    ctr_d       = init_ctr;
                    remaining_d = msg_len;
                    err_d       = 1'b0;
                    state_d     = (msg_len == '0) ? StFin : StGen;
                end
            end
            StGen: begin
                core_start = 1'b1;
                state_d    = StWait;
            end
            StWait: begin
                if (core_done) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                ser_load  = 1'b1;
                blk_cnt_d = '0;
                state_d   = StStream;
            end
            StStream: begin
                ks_valid = 1'b1;
                if (ks_ready) begin
                    remaining_d = remaining_q - 1'b1;
                    blk_cnt_d   = blk_cnt_q + 1'b1;
                    // Length exhaustion wins over a block boundary on the same beat.
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = StFin;
                    end else if (blk_cnt_q == BLK_W'(BLOCK_BYTES - 1)) begin
                        if (ctr_q == '1) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            ctr_d   = ctr_q + 1'b1;
                            state_d = StGen;
                        end
                    end
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Cancel keeps this cycle's pulses but discards any error raised by it.
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            err_d   = err_q;
        end
    end

    assign beat     = ks_valid && ks_ready;
    assign ser_step = beat;
    assign ks_last  = ks_valid && (remaining_q == LEN_W'(1));
    assign ks_byte  = ser_byte;
    assign core_ctr = ctr_q;
    assign busy     = (state_q != StIdle);
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ctr_q       <= '0;
            remaining_q <= '0;
            blk_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            remaining_q <= remaining_d;
            blk_cnt_q   <= blk_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_chacha_keystream_ctrl.sv
// Randomized bench for chacha_keystream_ctrl with a block-core and serialiser
// model; expectations come from a length/counter model of each request.
module tb_chacha_keystream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] init_ctr = '0;
    logic [15:0] msg_len = '0;
    logic        abort = 1'b0;
    logic        core_start;
    logic [31:0] core_ctr;
    logic        core_done = 1'b0;
    logic        ser_load;
    logic        ser_step;
    logic [7:0]  ser_byte;
    logic [7:0]  ks_byte;
    logic        ks_valid;
    logic        ks_ready = 1'b0;
    logic        ks_last;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    chacha_keystream_ctrl #(.LEN_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .init_ctr   (init_ctr),
        .msg_len    (msg_len),
        .abort      (abort),
        .core_start (core_start),
        .core_ctr   (core_ctr),
        .core_done  (core_done),
        .ser_load   (ser_load),
        .ser_step   (ser_step),
        .ser_byte   (ser_byte),
        .ks_byte    (ks_byte),
        .ks_valid   (ks_valid),
        .ks_ready   (ks_ready),
        .ks_last    (ks_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Keystream byte i of the block produced for counter c.
    function automatic logic [7:0] ks_fn(input logic [31:0] c, input int unsigned i);
        logic [31:0] h;
        h = c * 32'h9E37_79B1 + i * 32'h85EB_CA6B;
        h = h ^ (h >> 15);
        return h[7:0] ^ h[23:16];
    endfunction

    // Block core with random latency, and a byte serialiser.
    int unsigned core_cnt = 0;
    logic [31:0] blk_ctr  = '0;
    logic [31:0] ser_ctr  = '0;
    int unsigned ser_idx  = 0;

    always @(posedge clk) begin
        if (core_start) begin
            core_cnt <= $urandom_range(4, 1);
            blk_ctr  <= core_ctr;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
        end
        core_done <= !core_start && (core_cnt == 1);
        if (ser_load) begin
            ser_idx <= 0;
            ser_ctr <= blk_ctr;
        end else if (ser_step) begin
            ser_idx <= ser_idx + 1;
        end
    end

    assign ser_byte = ks_fn(ser_ctr, ser_idx);

    // Observed activity, sampled mid-cycle.
    logic [31:0] ctr_seen[$];
    logic [7:0]  byte_seen[$];
    logic        last_seen[$];
    int          n_done = 0;
    int          n_step = 0;
    int          n_load = 0;
    bit          stall_prev = 0;
    bit          last_prev = 0;
    bit          done_prev = 0;
    logic [7:0]  byte_prev = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (last_prev) check_eq("done_after_last", done, 1);
            if (done_prev) check_eq("idle_after_done", busy, 0);
            if (stall_prev) begin
                check_eq("valid_held_in_stall", ks_valid, 1);
                check_eq("byte_held_in_stall", ks_byte, byte_prev);
            end
            if (core_start) ctr_seen.push_back(core_ctr);
            if (ser_load) n_load++;
            if (ser_step) n_step++;
            if (done) n_done++;
            if (ks_valid && ks_ready) begin
                byte_seen.push_back(ks_byte);
                last_seen.push_back(ks_last);
            end
            stall_prev = ks_valid && !ks_ready;
            last_prev  = ks_valid && ks_ready && ks_last;
            done_prev  = done;
            byte_prev  = ks_byte;
        end else begin
            stall_prev = 0;
            last_prev  = 0;
            done_prev  = 0;
        end
    end

    task automatic clear_obs();
        ctr_seen.delete();
        byte_seen.delete();
        last_seen.delete();
        n_done = 0;
        n_step = 0;
        n_load = 0;
    endtask

    function automatic logic rand_ready(input int unsigned pct);
        return ($urandom_range(99, 0) < pct);
    endfunction

    task automatic run_req(input logic [31:0] c, input int unsigned len,
                           input int unsigned pct, input bit inject);
        longint unsigned nb, allowed, exp_blocks, exp_bytes;
        bit exp_err, injected;
        int cycles;
        nb         = (longint'(len) + 63) / 64;
        allowed    = 64'h1_0000_0000 - longint'(c);
        exp_err    = nb > allowed;
        exp_blocks = exp_err ? allowed : nb;
        exp_bytes  = exp_err ? allowed * 64 : longint'(len);
        injected   = 0;
        clear_obs();

        @(posedge clk); #1;
        start    = 1'b1;
        init_ctr = c;
        msg_len  = 16'(len);
        ks_ready = rand_ready(pct);
        @(posedge clk); #1;
        start    = 1'b0;
        init_ctr = $urandom;
        msg_len  = 16'($urandom);
        check_eq("busy_after_start", busy, 1);
        check_eq("core_start_after_start", core_start, len != 0);
        check_eq("err_cleared_on_start", err, 0);
        if (len == 0) check_eq("zero_len_done", done, 1);

        cycles = 0;
        while (busy && cycles < 4000) begin
            start    = 1'b0;
            ks_ready = rand_ready(pct);
            if (inject && !injected && ks_valid) begin
                start    = 1'b1;
                init_ctr = $urandom;
                msg_len  = 16'($urandom_range(500, 1));
                injected = 1;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start    = 1'b0;
        ks_ready = 1'b0;
        @(posedge clk); #1;

        check_eq("terminates", busy, 0);
        check_eq("err_flag", err, exp_err);
        check_eq("done_count", n_done, exp_err ? 0 : 1);
        check_eq("core_start_count", ctr_seen.size(), exp_blocks);
        check_eq("ser_load_count", n_load, exp_blocks);
        check_eq("ser_step_count", n_step, exp_bytes);
        check_eq("beat_count", byte_seen.size(), exp_bytes);
        foreach (ctr_seen[i]) check_eq("core_ctr_seq", ctr_seen[i], 32'(c + i));
        foreach (byte_seen[k]) begin
            check_eq("ks_byte", byte_seen[k], ks_fn(32'(c + k / 64), k % 64));
            check_eq("ks_last", last_seen[k], (!exp_err && k == len - 1));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_core_start"}, core_start, 0);
        check_eq({tag, "_ser_load"}, ser_load, 0);
        check_eq({tag, "_ser_step"}, ser_step, 0);
        check_eq({tag, "_ks_valid"}, ks_valid, 0);
        check_eq({tag, "_ks_last"}, ks_last, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cycles;
        logic [31:0] c;

        #12;
        check_idle_outputs("reset");
        check_eq("reset_err", err, 0);
        check_eq("reset_core_ctr", core_ctr, 0);
        check_eq("reset_ks_byte", ks_byte, ser_byte);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_req(32'd1, 64, 100, 0);
        run_req(32'd7, 150, 100, 0);
        run_req($urandom, 100, 50, 0);
        run_req(32'hFFFF_FFFF, 65, 100, 0);
        run_req(32'd5, 0, 100, 0);
        run_req(32'd9, 130, 70, 1);
        run_req(32'hFFFF_FFFE, 200, 60, 0);
        for (int t = 0; t < 10; t++) begin
            c = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF - $urandom_range(2, 0) : $urandom;
            run_req(c, $urandom_range(300, 0), $urandom_range(100, 20), t[0]);
        end

        // Abort while waiting on the core: no done, no load from the late core_done.
        clear_obs();
        @(posedge clk); #1;
        start = 1'b1; init_ctr = 32'd3; msg_len = 16'd100;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_idle_outputs("abort_wait");
        repeat (6) @(posedge clk);
        #1;
        check_eq("abort_stays_idle", busy, 0);
        check_eq("abort_no_done", n_done, 0);
        check_eq("abort_no_load", n_load, 0);
        check_eq("abort_err_unchanged", err, 0);

        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; msg_len = 16'd10;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_idle", busy, 0);
        check_eq("start_abort_no_gen", core_start, 0);

        // Asynchronous reset in the middle of streaming.
        clear_obs();
        @(posedge clk); #1;
        start = 1'b1; init_ctr = 32'd11; msg_len = 16'd200; ks_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cycles = 0;
        while (!ks_valid && wait_cycles < 50) begin
            @(posedge clk); #1;
            wait_cycles++;
        end
        check_eq("reached_stream", ks_valid, 1);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        check_eq("async_reset_err", err, 0);
        check_eq("async_reset_core_ctr", core_ctr, 0);
        check_eq("async_reset_ks_byte", ks_byte, ser_byte);
        ks_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("async_reset_no_done", n_done, 0);
        repeat (6) @(posedge clk);

        run_req(32'd42, 90, 80, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
